// File: rtl/tx_port_channel_gate_64_if.sv
// TX channel gate interface: user-side transaction signalling plus the
// event-FIFO read port that feeds tx_port_monitor_64.
interface tx_port_channel_gate_64_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic                    CHNL_TX;
  logic                    CHNL_TX_ACK;
  logic                    CHNL_TX_LAST;
  logic [31:0]             CHNL_TX_LEN;
  logic [30:0]             CHNL_TX_OFF;
  logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA;
  logic                    CHNL_TX_DATA_VALID;
  logic                    CHNL_TX_DATA_REN;
  logic [C_DATA_WIDTH:0]   EVT_DATA;
  logic                    EVT_DATA_EMPTY;
  logic                    EVT_DATA_RD_EN;

  // Driver side: user channel plus the monitor's read request.
  modport master (
    output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    output CHNL_TX_DATA, CHNL_TX_DATA_VALID, EVT_DATA_RD_EN,
    input  CHNL_TX_ACK, CHNL_TX_DATA_REN, EVT_DATA, EVT_DATA_EMPTY
  );

  // Gate side.
  modport slave (
    input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    input  CHNL_TX_DATA, CHNL_TX_DATA_VALID, EVT_DATA_RD_EN,
    output CHNL_TX_ACK, CHNL_TX_DATA_REN, EVT_DATA, EVT_DATA_EMPTY
  );
endinterface

// File: rtl/tx_port_channel_gate_64.sv
// TX channel gate: turns transaction open/close into pairs of event words,
// forwards payload beats as data words, and queues everything in a 65-bit
// synchronous FIFO whose registered head feeds the TX port monitor.
module tx_port_channel_gate_64 #(
  parameter int C_DATA_WIDTH       = 64,
  parameter int C_FIFO_DEPTH       = 16,
  parameter int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH))+1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  tx_port_channel_gate_64_if.slave chnl
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int WW = C_DATA_WIDTH + 1;
  localparam logic [C_FIFO_DEPTH_WIDTH-1:0] DEPTH_C = C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH);
  localparam logic [C_FIFO_DEPTH_WIDTH-1:0] ONE_C   = C_FIFO_DEPTH_WIDTH'(1);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_OPEN1  = 6'b000010,
    S_OPEN2  = 6'b000100,
    S_DATA   = 6'b001000,
    S_CLOSE1 = 6'b010000,
    S_CLOSE2 = 6'b100000
  } state_t;

  state_t                        state_q;
  logic [C_DATA_WIDTH-1:0]       hdr_q;
  logic [WW-1:0]                 mem_q [C_FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_q;
  logic [AW-1:0]                 rd_ptr_q;
  logic [C_FIFO_DEPTH_WIDTH-1:0] count_q;
  logic [WW-1:0]                 evt_q;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          ack;
  logic          ren;
  logic [WW-1:0] wr_data;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rd_en = chnl.EVT_DATA_RD_EN & ~empty;

  // Decode the write request and handshake outputs from state and FIFO fullness.
  always_comb begin
    wr_en   = 1'b0;
    ack     = 1'b0;
    ren     = 1'b0;
    wr_data = {1'b1, hdr_q};
    case (state_q)
      S_OPEN1: begin
        wr_en = ~full;
      end
      S_OPEN2: begin
        wr_en = ~full;
        ack   = ~full;
      end
      S_DATA: begin
        ren     = chnl.CHNL_TX & ~full;
        wr_en   = ren & chnl.CHNL_TX_DATA_VALID;
        wr_data = {1'b0, chnl.CHNL_TX_DATA};
      end
      S_CLOSE1, S_CLOSE2: begin
        wr_en   = ~full;
        wr_data = {1'b1, {C_DATA_WIDTH{1'b0}}};
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Transaction FSM; each event state advances only once its word is written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (chnl.CHNL_TX) begin
            hdr_q   <= {chnl.CHNL_TX_LEN, chnl.CHNL_TX_OFF, chnl.CHNL_TX_LAST};
            state_q <= S_OPEN1;
          end
        end
        S_OPEN1:  if (!full) state_q <= S_OPEN2;
        S_OPEN2:  if (!full) state_q <= S_DATA;
        S_DATA:   if (!chnl.CHNL_TX) state_q <= S_CLOSE1;
        S_CLOSE1: if (!full) state_q <= S_CLOSE2;
        S_CLOSE2: if (!full) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered read word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      evt_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        evt_q    <= mem_q[rd_ptr_q];
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  assign chnl.CHNL_TX_ACK      = ack;
  assign chnl.CHNL_TX_DATA_REN = ren;
  assign chnl.EVT_DATA         = evt_q;
  assign chnl.EVT_DATA_EMPTY   = empty;

endmodule

// File: tb/tb_tx_port_channel_gate_64.sv
// Scoreboard bench for tx_port_channel_gate_64: stimulus pushes expected
// event words, a monitor pops and compares every word read from the FIFO.
module tb_tx_port_channel_gate_64;

  localparam int DW = 64;
  localparam logic [64:0] CLOSE_W = {1'b1, 64'd0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_port_channel_gate_64_if #(.C_DATA_WIDTH(DW)) ifc ();

  tx_port_channel_gate_64 #(
    .C_DATA_WIDTH(DW),
    .C_FIFO_DEPTH(16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .chnl(ifc)
  );

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int ack_cnt = 0;
  int ren_cnt = 0;
  int acc = 0;
  logic pend = 1'b0;
  logic [64:0] exp_q[$];

  function automatic logic [64:0] hdr(logic [31:0] l, logic [30:0] o, logic la);
    return {1'b1, l, o, la};
  endfunction

  function automatic logic [63:0] beat(int tag, int n);
    return {16'hA5C3, 16'(tag), 32'(n)};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edge-side bookkeeping: read handshakes, ACK/REN cycles, accepted beats.
  always @(posedge clk) begin
    pend    <= ifc.EVT_DATA_RD_EN && !ifc.EVT_DATA_EMPTY && !rst;
    ack_cnt <= ack_cnt + (ifc.CHNL_TX_ACK ? 1 : 0);
    ren_cnt <= ren_cnt + (ifc.CHNL_TX_DATA_REN ? 1 : 0);
    if (ifc.CHNL_TX_DATA_REN && ifc.CHNL_TX_DATA_VALID && !rst) acc <= acc + 1;
  end

  // Monitor: each accepted read presents a word one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL evt_extra: got %h expected no word", ifc.EVT_DATA);
      end else begin
        check("evt_word", ifc.EVT_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !ifc.EVT_DATA_EMPTY) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drain_timeout"}, (n >= 300), 1'b0);
  endtask

  task automatic do_basic(input int tag);
    int p0, a0, b, n;
    p0 = pops; a0 = ack_cnt; b = acc;
    exp_q.push_back(hdr(32'd4, 31'h10, 1'b1));
    exp_q.push_back(hdr(32'd4, 31'h10, 1'b1));
    exp_q.push_back({1'b0, beat(tag, 0)});
    exp_q.push_back({1'b0, beat(tag, 1)});
    exp_q.push_back(CLOSE_W);
    exp_q.push_back(CLOSE_W);
    ifc.EVT_DATA_RD_EN = 1'b1;
    ifc.CHNL_TX_LEN = 32'd4; ifc.CHNL_TX_OFF = 31'h10; ifc.CHNL_TX_LAST = 1'b1;
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    ifc.CHNL_TX = 1'b1;
    @(negedge clk);
    check("basic_ack_t1", ifc.CHNL_TX_ACK, 1'b0);
    @(negedge clk);
    check("basic_ack_t2", ifc.CHNL_TX_ACK, 1'b1);
    check("basic_ren_t2", ifc.CHNL_TX_DATA_REN, 1'b0);
    @(negedge clk);
    check("basic_ren_t3", ifc.CHNL_TX_DATA_REN, 1'b1);
    ifc.CHNL_TX_DATA_VALID = 1'b1;
    ifc.CHNL_TX_DATA = beat(tag, 0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (acc - b >= 2) break;
      ifc.CHNL_TX_DATA = beat(tag, acc - b);
    end
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    ifc.CHNL_TX = 1'b0;
    check("basic_beats", 65'(acc - b), 65'd2);
    wait_drain("basic");
    check("basic_words", 65'(pops - p0), 65'd6);
    check("basic_ack_pulses", 65'(ack_cnt - a0), 65'd1);
  endtask

  task automatic run_short(input string name, input logic [31:0] len,
                           input logic [30:0] off, input logic last, input logic early);
    int p0, a0, r0;
    p0 = pops; a0 = ack_cnt; r0 = ren_cnt;
    exp_q.push_back(hdr(len, off, last));
    exp_q.push_back(hdr(len, off, last));
    exp_q.push_back(CLOSE_W);
    exp_q.push_back(CLOSE_W);
    ifc.EVT_DATA_RD_EN = 1'b1;
    ifc.CHNL_TX_LEN = len; ifc.CHNL_TX_OFF = off; ifc.CHNL_TX_LAST = last;
    ifc.CHNL_TX_DATA_VALID = 1'b1;
    ifc.CHNL_TX_DATA = 64'hDEAD_BEEF_0BAD_F00D;
    ifc.CHNL_TX = 1'b1;
    @(negedge clk);
    if (early) ifc.CHNL_TX = 1'b0;
    @(negedge clk);
    ifc.CHNL_TX = 1'b0;
    repeat (3) @(negedge clk);
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    wait_drain(name);
    check({name, "_words"}, 65'(pops - p0), 65'd4);
    check({name, "_ren_cycles"}, 65'(ren_cnt - r0), 65'd0);
    check({name, "_ack_pulses"}, 65'(ack_cnt - a0), 65'd1);
  endtask

  task automatic single_read;
    ifc.EVT_DATA_RD_EN = 1'b1;
    @(negedge clk);
    ifc.EVT_DATA_RD_EN = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_backpressure;
    int p0, b;
    p0 = pops; b = acc;
    exp_q.push_back(hdr(32'd40, 31'h0, 1'b0));
    exp_q.push_back(hdr(32'd40, 31'h0, 1'b0));
    for (int i = 0; i < 17; i++) exp_q.push_back({1'b0, beat(3, i)});
    exp_q.push_back(CLOSE_W);
    exp_q.push_back(CLOSE_W);
    ifc.EVT_DATA_RD_EN = 1'b0;
    ifc.CHNL_TX_LEN = 32'd40; ifc.CHNL_TX_OFF = 31'h0; ifc.CHNL_TX_LAST = 1'b0;
    ifc.CHNL_TX_DATA = beat(3, 0);
    ifc.CHNL_TX_DATA_VALID = 1'b1;
    ifc.CHNL_TX = 1'b1;
    repeat (40) begin
      @(negedge clk);
      ifc.CHNL_TX_DATA = beat(3, acc - b);
    end
    check("bp_beats_full", 65'(acc - b), 65'd14);
    check("bp_ren_full", ifc.CHNL_TX_DATA_REN, 1'b0);
    check("bp_count_full", 65'(dut.count_q), 65'd16);
    ifc.EVT_DATA_RD_EN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ifc.CHNL_TX_DATA = beat(3, acc - b);
    end
    ifc.EVT_DATA_RD_EN = 1'b0;
    repeat (20) begin
      @(negedge clk);
      ifc.CHNL_TX_DATA_VALID = (acc - b < 20);
      ifc.CHNL_TX_DATA = beat(3, acc - b);
    end
    check("bp_beats_after_reads", 65'(acc - b), 65'd17);
    ifc.CHNL_TX = 1'b0;
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    repeat (5) @(negedge clk);
    check("cf_count_hold", 65'(dut.count_q), 65'd16);
    check("cf_ren", ifc.CHNL_TX_DATA_REN, 1'b0);
    check("cf_ack", ifc.CHNL_TX_ACK, 1'b0);
    single_read();
    check("cf_close1_refill", 65'(dut.count_q), 65'd16);
    single_read();
    check("cf_close2_refill", 65'(dut.count_q), 65'd16);
    single_read();
    check("cf_no_third_close", 65'(dut.count_q), 65'd15);
    ifc.EVT_DATA_RD_EN = 1'b1;
    wait_drain("bp");
    check("bp_words", 65'(pops - p0), 65'd21);
  endtask

  task automatic do_async_reset;
    ifc.EVT_DATA_RD_EN = 1'b0;
    ifc.CHNL_TX_LEN = 32'd8; ifc.CHNL_TX_OFF = 31'h7; ifc.CHNL_TX_LAST = 1'b0;
    ifc.CHNL_TX = 1'b1;
    repeat (3) @(negedge clk);
    ifc.CHNL_TX_DATA_VALID = 1'b1;
    ifc.CHNL_TX_DATA = 64'h1111_2222_3333_4444;
    repeat (3) @(negedge clk);
    check("ar_pre_ren", ifc.CHNL_TX_DATA_REN, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_empty", ifc.EVT_DATA_EMPTY, 1'b1);
    check("ar_ren", ifc.CHNL_TX_DATA_REN, 1'b0);
    check("ar_ack", ifc.CHNL_TX_ACK, 1'b0);
    check("ar_evt", ifc.EVT_DATA, 65'd0);
    ifc.CHNL_TX = 1'b0;
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_empty_after", ifc.EVT_DATA_EMPTY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.CHNL_TX = 1'b0;
    ifc.CHNL_TX_LAST = 1'b0;
    ifc.CHNL_TX_LEN = '0;
    ifc.CHNL_TX_OFF = '0;
    ifc.CHNL_TX_DATA = '0;
    ifc.CHNL_TX_DATA_VALID = 1'b0;
    ifc.EVT_DATA_RD_EN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_empty", ifc.EVT_DATA_EMPTY, 1'b1);
    check("rst_evt", ifc.EVT_DATA, 65'd0);
    check("rst_ack", ifc.CHNL_TX_ACK, 1'b0);
    check("rst_ren", ifc.CHNL_TX_DATA_REN, 1'b0);

    do_basic(1);
    run_short("len0", 32'd0, 31'h5, 1'b0, 1'b0);
    run_short("early", 32'd16, 31'h4000_0001, 1'b1, 1'b1);
    do_backpressure();
    do_async_reset();
    do_basic(2);

    check("scoreboard_empty", 65'(exp_q.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_port_channel_gate_64.md
# tx_port_channel_gate_64

Single-clock gate between the user TX channel and `tx_port_monitor_64`. It converts the user's transaction-open and close signalling into event words and forwards payload beats as data words. Both kinds of word go through an internal synchronous FIFO, 65 bits wide, whose read side feeds the monitor's `EVT_DATA` port. Bit 64 of each FIFO word is the event flag.

## Interface
- `C_DATA_WIDTH`, 9'd64, payload width; only 64 is supported.
- `C_FIFO_DEPTH`, 16, internal FIFO depth in words; power of two, ≥ 4.
- `C_FIFO_DEPTH_WIDTH`, `clog2((2**clog2(C_FIFO_DEPTH))+1)`, width of the occupancy counter.
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- `CLK` input 1: sole clock; all logic on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `CHNL_TX` input 1: user holds high for the duration of a transaction.
- `CHNL_TX_ACK` output 1: one-cycle pulse; header accepted.
- `CHNL_TX_LAST` input 1: last-transaction flag.
- `CHNL_TX_LEN` input 32: length in 32-bit words.
- `CHNL_TX_OFF` input 31: offset.
- `CHNL_TX_DATA` input `C_DATA_WIDTH`: payload.
- `CHNL_TX_DATA_VALID` input 1: payload valid.
- `CHNL_TX_DATA_REN` output 1: gate accepts payload this cycle.
- `EVT_DATA` output `C_DATA_WIDTH+1`: FIFO read word; bit 64 is the event flag.
- `EVT_DATA_EMPTY` output 1: FIFO empty.
- `EVT_DATA_RD_EN` input 1: FIFO read request.

## Operation
Event word format:
- Header event: `{1'b1, LEN[31:0], OFF[30:0], LAST}`.
- Close event: `{1'b1, 64'd0}`.
- Data word: `{1'b0, CHNL_TX_DATA}`.

FSM states (one-hot) and transitions:
- **IDLE**
  - If `CHNL_TX`=1: latch LEN, OFF and LAST into a header register; go to OPEN_1.
- **OPEN_1**
  - If not full: write the header event; go to OPEN_2.
- **OPEN_2**
  - If not full: write the header event again; pulse `CHNL_TX_ACK`; go to DATA.
- **DATA**
  - `CHNL_TX_DATA_REN` = `CHNL_TX` & !full.
  - Beat transfers when `CHNL_TX_DATA_REN` & `CHNL_TX_DATA_VALID`; one data word is written.
  - If `CHNL_TX`=0: go to CLOSE_1; no write this cycle.
- **CLOSE_1**
  - If not full: write a close event; go to CLOSE_2.
- **CLOSE_2**
  - If not full: write a close event; go to IDLE.
- **Any other encoding** → IDLE.

Rules that apply in every state:
- The gate never writes when the FIFO is full; the FSM holds its state while full.
- Every transaction therefore produces exactly two header events, N data words, then two close events. This is what the monitor's NEXT → EVT_2 and END_0 → END_1 sequencing requires.
- `CHNL_TX` dropping during OPEN_1/OPEN_2:
  - Both headers are still written and ACK still pulses.
  - DATA is then left on its first cycle.
- LEN=0: headers and closes are written; zero data words.
- LEN is not enforced: beats continue to be accepted while `CHNL_TX`=1. Trimming excess beats is the monitor's job.

FIFO:
- Synchronous, occupancy counter `C_FIFO_DEPTH_WIDTH` bits wide.
- Full when count == `C_FIFO_DEPTH`.
- `EVT_DATA_EMPTY` = (count == 0).
- Read when `EVT_DATA_RD_EN` & !empty: `EVT_DATA` is registered and loads the head word on that edge. With no read, `EVT_DATA` holds its value.
- Read when empty: ignored; pointers and `EVT_DATA` are unchanged.
- Simultaneous read and write: count unchanged.
- Pointers wrap modulo `C_FIFO_DEPTH`.

## Timing
- Reset values:
  - State IDLE.
  - FIFO empty, so `EVT_DATA_EMPTY`=1.
  - `EVT_DATA`=0.
  - `CHNL_TX_ACK`=0, `CHNL_TX_DATA_REN`=0.
  - Header register 0.
- Reset mid-transaction flushes the FIFO and abandons the transaction; the user must re-raise `CHNL_TX`.
- Latency: `CHNL_TX` sampled high at edge T:
  - OPEN_1 during T+1; header 1 written at edge T+2.
  - OPEN_2 during T+2; ACK high; header 2 written at edge T+3.
  - `CHNL_TX_DATA_REN` may first be high during cycle T+3.
  - This assumes a non-full FIFO.
- `EVT_DATA_EMPTY` deasserts the cycle after the first write.
- Read latency: `EVT_DATA` is valid the cycle after the read request, consistent with the monitor qualifying data with `rRead & !EVT_DATA_EMPTY`.
- `CHNL_TX_ACK` and `CHNL_TX_DATA_REN` are combinational from state and full. They must not depend on `CHNL_TX_DATA_VALID`.

## Test plan
- **Basic transaction.** LEN=4, OFF=0x10, LAST=1; 2 beats A, B; `CHNL_TX` then drops; monitor-style reader always enabled.
  - Read sequence: two headers `{1,0x00000004,0x10,1}`, then `{0,A}`, `{0,B}`, then two `{1,0}`.
  - ACK is exactly one pulse, at T+2.
- **LEN=0.** Transaction with no beats.
  - Exactly 4 event words; `CHNL_TX_DATA_REN` never high.
- **Backpressure.** `C_FIFO_DEPTH`=16, no reads, 20 beats offered.
  - REN drops after 14 data words (2 headers + 14 = full).
  - After 3 reads, exactly 3 more beats are accepted; no word is lost or duplicated.
- **Close while full.** FIFO full when `CHNL_TX` drops.
  - FSM holds in CLOSE_1.
  - Each single read allows exactly one close event to be written.
- **Early drop.** `CHNL_TX` high for only 1 cycle.
  - Two headers, ACK pulse, two closes; zero data words.
- **Async reset.** `RST` asserted mid-DATA, between clock edges.
  - `EVT_DATA_EMPTY`=1 and ACK/REN=0 immediately.
  - After release, a new transaction produces the correct sequence.
